sha256_padder: RTL and testbench

SHA256_PADDER -- requirements
Module: sha256_padder

---
 rtl/sha256_padder.sv | 170 +++++++++++++++++
 tb/tb_sha256_padder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks,
// appends the 0x80 terminator and the 64-bit message bit length.
module sha256_padder #(
  parameter int unsigned LenWidth = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [31:0]  s_data_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic         s_last_i,
  input  logic [2:0]   s_nbytes_i,
  output logic [511:0] m_block_o,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic         m_first_o,
  output logic         m_last_o
);

  typedef enum logic [1:0] {ABSORB, OUT, PAD} state_t;

  state_t               state, state_n;
  logic [3:0]           w, w_n;
  logic [LenWidth-1:0]  bits, bits_n, len_last;
  logic                 pend, pend_n;
  logic                 pad, pad_n;
  logic                 in_msg, in_msg_n;
  logic [15:0][31:0]    blk, blk_n;
  logic                 first, first_n;
  logic                 last, last_n;

  logic [2:0]           nb;
  logic [6:0]           pos;
  logic [31:0]          tail_word;

  assign m_block_o = blk;
  assign m_first_o = first;
  assign m_last_o  = last;

  // Final-word decode: clamped byte count, 0x80 byte position, closing length.
  always_comb begin
    nb       = (s_nbytes_i > 3'd4) ? 3'd4 : s_nbytes_i;
    pos      = {1'b0, w, 2'b00} + {4'b0000, nb};
    len_last = bits + LenWidth'({nb, 3'b000});
    unique case (nb)
      3'd0:    tail_word = 32'h8000_0000;
      3'd1:    tail_word = {s_data_i[31:24], 24'h80_0000};
      3'd2:    tail_word = {s_data_i[31:16], 16'h8000};
      3'd3:    tail_word = {s_data_i[31:8], 8'h80};
      default: tail_word = s_data_i;
    endcase
  end

  always_comb begin
    state_n   = state;
    w_n       = w;
    bits_n    = bits;
    pend_n    = pend;
    pad_n     = pad;
    in_msg_n  = in_msg;
    blk_n     = blk;
    first_n   = first;
    last_n    = last;
    s_ready_o = 1'b0;
    m_valid_o = 1'b0;

    unique case (state)
      ABSORB: begin
        s_ready_o = rst_ni;
        if (s_valid_i) begin
          if (!s_last_i) begin
            for (int unsigned i = 0; i < 16; i++) begin
              if (4'(i) == w) blk_n[4'(15 - i)] = s_data_i;
            end
            bits_n = bits + LenWidth'(32);
            if (w == 4'd15) begin
              state_n = OUT;
              w_n     = '0;
              first_n = ~in_msg;
              last_n  = 1'b0;
              pad_n   = 1'b0;
            end else begin
              w_n = w + 4'd1;
            end
          end else begin
            // Words past the final one are cleared here, so stale data from a
            // previous block never needs an explicit wipe.
            for (int unsigned i = 0; i < 16; i++) begin
              if (4'(i) == w)
                blk_n[4'(15 - i)] = tail_word;
              else if (5'(i) == ({1'b0, w} + 5'd1) && nb == 3'd4)
                blk_n[4'(15 - i)] = 32'h8000_0000;
              else if (4'(i) > w)
                blk_n[4'(15 - i)] = '0;
            end
            bits_n  = len_last;
            w_n     = '0;
            state_n = OUT;
            first_n = ~in_msg;
            if (pos <= 7'd55) begin
              blk_n[1:0] = len_last;
              last_n     = 1'b1;
              pad_n      = 1'b0;
            end else begin
              last_n = 1'b0;
              pad_n  = 1'b1;
              pend_n = (pos == 7'd64);
            end
          end
        end
      end

      OUT: begin
        m_valid_o = 1'b1;
        if (m_ready_i) begin
          if (pad) begin
            state_n = PAD;
          end else begin
            state_n = ABSORB;
            w_n     = '0;
          end
          if (last) begin
            bits_n   = '0;
            in_msg_n = 1'b0;
          end else begin
            in_msg_n = 1'b1;
          end
        end
      end

      PAD: begin
        blk_n = '0;
        if (pend) blk_n[15] = 32'h8000_0000;
        blk_n[1:0] = bits;
        first_n    = 1'b0;
        last_n     = 1'b1;
        pend_n     = 1'b0;
        pad_n      = 1'b0;
        state_n    = OUT;
      end

      default: state_n = ABSORB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= ABSORB;
      w      <= '0;
      bits   <= '0;
      pend   <= 1'b0;
      pad    <= 1'b0;
      in_msg <= 1'b0;
      blk    <= '0;
      first  <= 1'b0;
      last   <= 1'b0;
    end else begin
      state  <= state_n;
      w      <= w_n;
      bits   <= bits_n;
      pend   <= pend_n;
      pad    <= pad_n;
      in_msg <= in_msg_n;
      blk    <= blk_n;
      first  <= first_n;
      last   <= last_n;
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: reference SHA-256 padding of byte
// messages is queued per message and compared against each accepted block.
module tb_sha256_padder;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic [31:0]  s_data_i = '0;
  logic         s_valid_i = 1'b0;
  logic         s_ready_o;
  logic         s_last_i = 1'b0;
  logic [2:0]   s_nbytes_i = '0;
  logic [511:0] m_block_o;
  logic         m_valid_o;
  logic         m_ready_i = 1'b1;
  logic         m_first_o;
  logic         m_last_o;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  bit   rand_rdy = 1'b0;

  sha256_padder #(.LenWidth(64)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .s_data_i   (s_data_i),
    .s_valid_i  (s_valid_i),
    .s_ready_o  (s_ready_o),
    .s_last_i   (s_last_i),
    .s_nbytes_i (s_nbytes_i),
    .m_block_o  (m_block_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_first_o  (m_first_o),
    .m_last_o   (m_last_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    #2;
    if (rand_rdy) m_ready_i = 1'($urandom_range(0, 1));
  end

  // Block monitor: a handshake seen here completes on the next rising edge.
  always @(negedge clk_i) begin
    if (rst_ni && m_valid_o && m_ready_i) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_block: got %h with no block expected", m_block_o);
      end else begin
        mon_e = exp_q.pop_front();
        total += 3;
        if (m_block_o !== mon_e.blk) begin
          bad++;
          $display("FAIL block_data: got %h required %h", m_block_o, mon_e.blk);
        end
        if (m_first_o !== mon_e.first) begin
          bad++;
          $display("FAIL block_first: got %b required %b", m_first_o, mon_e.first);
        end
        if (m_last_o !== mon_e.last) begin
          bad++;
          $display("FAIL block_last: got %b required %b", m_last_o, mon_e.last);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic bq_t rand_msg(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom()));
    return q;
  endfunction

  task automatic push_model(input bq_t msg);
    bq_t p;
    exp_t e;
    logic [63:0] nbits;
    int nblk;
    p = msg;
    nbits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(8'(nbits >> (8 * k)));
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e.blk = '0;
      for (int j = 0; j < 64; j++) e.blk[511 - 8*j -: 8] = p[64*b + j];
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk_i);
    #2 m_ready_i = v;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
  endtask

  // Drives a byte message as words; unused bytes of the final word are random.
  task automatic send_msg(input bq_t msg, input bit gaps);
    int nw, nb, idx, cnt;
    logic [31:0] d;
    bit lst;
    nw = (msg.size() + 3) / 4;
    if (nw == 0) nw = 1;
    for (int wi = 0; wi < nw; wi++) begin
      d  = $urandom();
      nb = 0;
      for (int b = 0; b < 4; b++) begin
        idx = wi*4 + b;
        if (idx < msg.size()) begin
          d[31 - 8*b -: 8] = msg[idx];
          nb++;
        end
      end
      lst = (wi == nw - 1);
      s_data_i  = d;
      s_last_i  = lst;
      s_valid_i = 1'b1;
      if (!lst)
        s_nbytes_i = 3'($urandom_range(0, 7));
      else if (nb == 4 && $urandom_range(0, 1) == 1)
        s_nbytes_i = 3'($urandom_range(5, 7));
      else
        s_nbytes_i = 3'(nb);
      cnt = 0;
      while (!s_ready_o && cnt < 3000) begin
        @(negedge clk_i);
        cnt++;
      end
      if (!s_ready_o) begin
        total++; bad++;
        $display("FAIL input_accept: s_ready_o stayed %b, required 1", s_ready_o);
        s_valid_i = 1'b0;
        return;
      end
      @(posedge clk_i);
      @(negedge clk_i);
      s_valid_i = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk_i);
    end
  endtask

  task automatic push_abc();
    exp_t e;
    e.blk   = {32'h6162_6380, 448'b0, 32'h0000_0018};
    e.first = 1'b1;
    e.last  = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    total += 5;
    if (m_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", m_valid_o); end
    if (m_block_o !== 512'b0) begin bad++; $display("FAIL reset_block: got %h required 0", m_block_o); end
    if (m_first_o !== 1'b0) begin bad++; $display("FAIL reset_first: got %b required 0", m_first_o); end
    if (m_last_o !== 1'b0) begin bad++; $display("FAIL reset_last: got %b required 0", m_last_o); end
    if (s_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready_held: got %b required 0", s_ready_o); end
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    total++;
    if (s_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b required 1", s_ready_o); end
  endtask

  task automatic test_abc();
    bq_t m;
    m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
    push_abc();
    send_msg(m, 1'b0);
    total++;
    if (m_valid_o !== 1'b1) begin bad++; $display("FAIL abc_latency: m_valid_o got %b required 1", m_valid_o); end
    wait_drain();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL abc_drain: pending got %0d required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_empty();
    bq_t m;
    exp_t e;
    e.blk   = {32'h8000_0000, 480'b0};
    e.first = 1'b1;
    e.last  = 1'b1;
    exp_q.push_back(e);
    send_msg(m, 1'b0);
    wait_drain();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL empty_drain: pending got %0d required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_len(input int n);
    bq_t m;
    m = rand_msg(n);
    push_model(m);
    send_msg(m, 1'b1);
    wait_drain();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL len%0d_drain: pending got %0d required 0", n, exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_stall();
    bq_t m;
    logic [511:0] want;
    m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
    set_ready(1'b0);
    push_abc();
    want = exp_q[0].blk;
    send_msg(m, 1'b0);
    for (int k = 0; k < 5; k++) begin
      total += 5;
      if (m_valid_o !== 1'b1) begin bad++; $display("FAIL stall_valid: cycle %0d got %b required 1", k, m_valid_o); end
      if (m_block_o !== want) begin bad++; $display("FAIL stall_block: cycle %0d got %h required %h", k, m_block_o, want); end
      if (m_first_o !== 1'b1) begin bad++; $display("FAIL stall_first: cycle %0d got %b required 1", k, m_first_o); end
      if (m_last_o !== 1'b1) begin bad++; $display("FAIL stall_last: cycle %0d got %b required 1", k, m_last_o); end
      if (s_ready_o !== 1'b0) begin bad++; $display("FAIL stall_ready: cycle %0d got %b required 0", k, s_ready_o); end
      s_data_i   = $urandom();
      s_last_i   = 1'b1;
      s_nbytes_i = 3'd2;
      s_valid_i  = 1'b1;
      @(negedge clk_i);
    end
    s_valid_i = 1'b0;
    set_ready(1'b1);
    wait_drain();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL stall_drain: pending got %0d required 0", exp_q.size()); exp_q.delete(); end
    test_len(5);
  endtask

  task automatic test_reset_mid();
    bq_t m;
    for (int k = 0; k < 7; k++) begin
      s_data_i   = $urandom();
      s_last_i   = 1'b0;
      s_nbytes_i = 3'd4;
      s_valid_i  = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
    end
    s_valid_i = 1'b0;
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    total += 5;
    if (m_valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b required 0", m_valid_o); end
    if (m_block_o !== 512'b0) begin bad++; $display("FAIL midrst_block: got %h required 0", m_block_o); end
    if (m_first_o !== 1'b0) begin bad++; $display("FAIL midrst_first: got %b required 0", m_first_o); end
    if (m_last_o !== 1'b0) begin bad++; $display("FAIL midrst_last: got %b required 0", m_last_o); end
    if (s_ready_o !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b required 0", s_ready_o); end
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
    push_abc();
    send_msg(m, 1'b0);
    wait_drain();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL midrst_drain: pending got %0d required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    int lens[16] = '{0, 1, 3, 4, 5, 52, 55, 56, 59, 60, 63, 64, 65, 119, 120, 128};
    bq_t m;
    rand_rdy = 1'b1;
    for (int k = 0; k < 16 + 8; k++) begin
      m = rand_msg((k < 16) ? lens[k] : $urandom_range(0, 200));
      push_model(m);
      send_msg(m, 1'b1);
    end
    wait_drain();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: pending got %0d required 0", exp_q.size()); exp_q.delete(); end
    rand_rdy = 1'b0;
    set_ready(1'b1);
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_len(56);
    test_len(64);
    test_len(55);
    test_len(60);
    test_stall();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
